score_tally: RTL and testbench
==============================

SCORE_TALLY -- requirements
Module: score_tally

Interface
REQ-001 SHALL expose parameter N_LANES, default 6, number of dropper lanes consumed.
REQ-002 SHALL expose parameter MISS_Y, default 360, top-Y at which an unhit arrow counts as missed (arrow top + 40 >= 400).
REQ-003 SHALL expose parameter SCORE_MAX, default 9999, saturation limit of total score.
REQ-004 Port frame_clk  in  1  frame clock; all state updates on its rising edge.
REQ-005 Port Reset  in  1  synchronous, active-high reset.
REQ-006 Port keycode  in  8  primary USB keycode; 0x2C = start, 0x01 = return to idle.
REQ-007 Port score_in  in  N_LANES  per-lane score level from each dropper; held high once the lane is hit.
REQ-008 Port drop_y  in  N_LANES x 10  per-lane arrow top-Y from each dropper.
REQ-009 Port total_score  out  14  binary total score, 0..SCORE_MAX.
REQ-010 Port combo  out  8  current consecutive-hit count.
REQ-011 Port max_combo  out  8  highest combo this round.
REQ-012 Port hit_count, miss_count  out  8 each  resolved lanes by outcome.
REQ-013 Port score_bcd  out  16  four BCD digits of total_score, thousands in [15:12].
REQ-014 Port game_over  out  1  high in DONE state.

Function
REQ-015 SHALL implement states IDLE, PLAY, DONE.
REQ-016 IDLE: all counters, score, resolved flags, score_in history cleared each cycle; keycode==0x2C -> PLAY next cycle.
REQ-017 PLAY: per lane i not yet resolved, hit event when score_in[i]==1 and previous-cycle score_in[i]==0.
REQ-018 PLAY: per lane i not yet resolved, miss event when drop_y[i] >= MISS_Y and score_in[i]==0; hit takes priority if both.
REQ-019 Each event SHALL set lane i resolved; resolved lanes generate no further events until IDLE.
REQ-020 Hit points = 10 x multiplier; multiplier 1 if pre-cycle combo<4, 2 if 4..7, 4 if >=8.
REQ-021 Multiple hits in one cycle: each scored with pre-cycle combo; combo += number of hits, saturating at 255.
REQ-022 Any miss in a cycle: combo = 0 after that cycle, regardless of simultaneous hits; hits still scored.
REQ-023 max_combo updated to max(max_combo, new combo) in the same cycle combo changes.
REQ-024 total_score SHALL saturate at SCORE_MAX; hit_count/miss_count saturate at 255.
REQ-025 PLAY -> DONE in the cycle after all N_LANES resolved; keycode==0x01 in PLAY or DONE -> IDLE.
REQ-026 DONE: all counters frozen, game_over=1; keycode 0x2C ignored.
REQ-027 Outputs registered; counter outputs reflect an event one cycle after the input edge.
REQ-028 score_bcd SHALL be produced by a sequential shift-add converter: snapshot total_score when it differs from last converted value and converter idle; 14 shift cycles; score_bcd updated once, at most 16 cycles after total_score settles; score_bcd never shows partial results.
REQ-029 total_score change during conversion SHALL be picked up by the next conversion, not abort the current one.

Reset
REQ-030 Reset SHALL force IDLE, all outputs 0 (score_bcd=0x0000, game_over=0), converter idle, in the cycle it is sampled, overriding keycode and events, including mid-conversion and mid-PLAY.

Structure
REQ-031 Shared package rhythm_pkg SHALL hold state enum, N_LANES default, KEY_START=0x2C, KEY_IDLE=0x01, MISS_Y, SCORE_MAX, points/multiplier thresholds.
REQ-032 One sub-module bin2bcd_seq (start/busy/done, 14-bit in, 16-bit BCD out) SHALL implement REQ-028.

Verification
REQ-033 Reset, 0x2C, rising score_in[0] -> next cycle total_score=10, combo=1, hit_count=1; within 16 cycles score_bcd=0x0010.
REQ-034 Five sequential single-lane hits -> scores 10,10,10,10,20; total 60; combo 5; max_combo 5.
REQ-035 Hit lane 1 and drop_y[2]=360 same cycle -> total +10, combo 0, hit_count 1, miss_count 1.
REQ-036 All 6 lanes resolved -> game_over=1 next cycle; further score_in edges ignored; 0x01 -> IDLE, all outputs 0.
REQ-037 Preload near saturation (force many hits at multiplier 4) -> total_score stops at 9999, score_bcd=0x9999.
REQ-038 Reset asserted during bin2bcd conversion and during PLAY -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game score path.
package rhythm_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_DONE = 2'd2} state_t;

  localparam int N_LANES_DEF   = 6;
  localparam int MISS_Y_DEF    = 360;
  localparam int SCORE_MAX_DEF = 9999;
  localparam int SCORE_W       = 14;
  localparam int Y_W           = 10;
  localparam int BCD_W         = 16;

  localparam logic [7:0] KEY_START = 8'h2C;
  localparam logic [7:0] KEY_IDLE  = 8'h01;

  localparam int HIT_POINTS = 10;
  localparam int COMBO_X2   = 4;
  localparam int COMBO_X4   = 8;

  function automatic logic [2:0] combo_mult(input logic [7:0] combo);
    if (combo >= 8'(COMBO_X4)) return 3'd4;
    if (combo >= 8'(COMBO_X2)) return 3'd2;
    return 3'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = 17'(a) + 17'(b);
    return (s > 17'd255) ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/score_tally_if.sv
// Dropper-facing inputs and score outputs of the tally block.
interface score_tally_if import rhythm_pkg::*; #(
  parameter int N_LANES = N_LANES_DEF
) ();
  logic [7:0]                    keycode;
  logic [N_LANES-1:0]            score_in;
  logic [N_LANES-1:0][Y_W-1:0]   drop_y;
  logic [SCORE_W-1:0]            total_score;
  logic [7:0]                    combo;
  logic [7:0]                    max_combo;
  logic [7:0]                    hit_count;
  logic [7:0]                    miss_count;
  logic [BCD_W-1:0]              score_bcd;
  logic                          game_over;

  modport master (
    output keycode, score_in, drop_y,
    input  total_score, combo, max_combo, hit_count, miss_count, score_bcd, game_over
  );

  modport slave (
    input  keycode, score_in, drop_y,
    output total_score, combo, max_combo, hit_count, miss_count, score_bcd, game_over
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, result valid with o_done.
module bin2bcd_seq import rhythm_pkg::*; #(
  parameter int BIN_W  = SCORE_W,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_shift;

  // Add-3 on every digit that would overflow past 9 after the next doubling.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++)
      if (r_work[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
  end

  assign w_shift = {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_work <= w_shift;
        r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_bin  <= i_bin;
        r_work <= '0;
        r_cnt  <= CNT_W'(BIN_W);
        r_busy <= 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_work;
endmodule

// File: rtl/score_tally.sv
// Per-round hit/miss scoring with combo multiplier and a lazily refreshed BCD score.
module score_tally import rhythm_pkg::*; #(
  parameter int N_LANES   = N_LANES_DEF,
  parameter int MISS_Y    = MISS_Y_DEF,
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic          frame_clk,
  input  logic          Reset,
  score_tally_if.slave  bus
);
  localparam int NW    = $clog2(N_LANES + 1);
  localparam int SUM_W = SCORE_W + NW + 6;

  state_t              r_state;
  logic [N_LANES-1:0]  r_prev;
  logic [N_LANES-1:0]  r_resolved;
  logic [SCORE_W-1:0]  r_total;
  logic [SCORE_W-1:0]  r_last_conv;
  logic [7:0]          r_combo;
  logic [7:0]          r_max_combo;
  logic [7:0]          r_hit_cnt;
  logic [7:0]          r_miss_cnt;
  logic                r_game_over;
  logic [BCD_W-1:0]    r_bcd;

  logic [N_LANES-1:0]  w_hit;
  logic [N_LANES-1:0]  w_miss;
  logic [N_LANES-1:0]  w_res_nxt;
  logic [NW-1:0]       w_nhit;
  logic [NW-1:0]       w_nmiss;
  logic [SUM_W-1:0]    w_sum;
  logic [SCORE_W-1:0]  w_total_nxt;
  logic [7:0]          w_combo_nxt;
  logic                w_to_idle;
  logic                w_clear;
  logic                w_conv_start;
  logic                w_conv_busy;
  logic                w_conv_done;
  logic [BCD_W-1:0]    w_conv_bcd;

  // A lane's hit wins over its miss because a miss requires score_in low.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign w_hit[i]  = ~r_resolved[i] & bus.score_in[i] & ~r_prev[i];
    assign w_miss[i] = ~r_resolved[i] & ~bus.score_in[i] &
                       (bus.drop_y[i] >= Y_W'(MISS_Y));
  end

  assign w_res_nxt = r_resolved | w_hit | w_miss;

  always_comb begin
    w_nhit  = '0;
    w_nmiss = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_nhit  = w_nhit  + NW'(w_hit[i]);
      w_nmiss = w_nmiss + NW'(w_miss[i]);
    end
  end

  // Every hit in a cycle uses the multiplier of the combo held before the cycle.
  assign w_sum = SUM_W'(r_total) +
                 SUM_W'(w_nhit) * SUM_W'(HIT_POINTS) * SUM_W'(combo_mult(r_combo));
  assign w_total_nxt = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : w_sum[SCORE_W-1:0];
  assign w_combo_nxt = (|w_miss) ? 8'd0 : sat_add8(r_combo, 16'(w_nhit));

  assign w_to_idle = ((r_state == ST_PLAY) || (r_state == ST_DONE)) && (bus.keycode == KEY_IDLE);
  assign w_clear   = w_to_idle || ((r_state != ST_PLAY) && (r_state != ST_DONE));

  always_ff @(posedge frame_clk) begin
    if (Reset || w_clear) begin
      r_state     <= (!Reset && (r_state == ST_IDLE) && (bus.keycode == KEY_START)) ? ST_PLAY : ST_IDLE;
      r_prev      <= '0;
      r_resolved  <= '0;
      r_total     <= '0;
      r_combo     <= '0;
      r_max_combo <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_game_over <= 1'b0;
    end else if (r_state == ST_PLAY) begin
      r_prev      <= bus.score_in;
      r_resolved  <= w_res_nxt;
      r_total     <= w_total_nxt;
      r_combo     <= w_combo_nxt;
      r_max_combo <= (w_combo_nxt > r_max_combo) ? w_combo_nxt : r_max_combo;
      r_hit_cnt   <= sat_add8(r_hit_cnt, 16'(w_nhit));
      r_miss_cnt  <= sat_add8(r_miss_cnt, 16'(w_nmiss));
      r_game_over <= &w_res_nxt;
      if (&w_res_nxt) r_state <= ST_DONE;
    end
  end

  // Convert only when the score moved; a change mid-conversion is caught next round.
  assign w_conv_start = ~w_conv_busy & (r_total != r_last_conv);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_last_conv <= '0;
      r_bcd       <= '0;
    end else begin
      if (w_conv_start) r_last_conv <= r_total;
      if (w_conv_done)  r_bcd       <= w_conv_bcd;
    end
  end

  bin2bcd_seq #(.BIN_W(SCORE_W), .DIGITS(BCD_W / 4)) u_bcd (
    .clk     (frame_clk),
    .rst     (Reset),
    .i_start (w_conv_start),
    .i_bin   (r_total),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_conv_bcd)
  );

  assign bus.total_score = r_total;
  assign bus.combo       = r_combo;
  assign bus.max_combo   = r_max_combo;
  assign bus.hit_count   = r_hit_cnt;
  assign bus.miss_count  = r_miss_cnt;
  assign bus.score_bcd   = r_bcd;
  assign bus.game_over   = r_game_over;
endmodule

// File: tb/tb_score_tally.sv
// Randomised bench for score_tally against a rule-level round model.
module tb_score_tally;
  import rhythm_pkg::*;

  localparam int NL  = 6;
  localparam int BIG = 260;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b0;
  always #5 frame_clk = ~frame_clk;

  score_tally_if #(.N_LANES(NL))  bus  ();
  score_tally_if #(.N_LANES(BIG)) bbus ();

  score_tally #(.N_LANES(NL), .MISS_Y(360), .SCORE_MAX(9999)) dut (
    .frame_clk (frame_clk), .Reset (Reset), .bus (bus));
  score_tally #(.N_LANES(BIG)) dut_big (
    .frame_clk (frame_clk), .Reset (Reset), .bus (bbus));

  int n_cmp = 0;
  int n_err = 0;

  // Round model for the 6-lane instance: 0 idle, 1 play, 2 done.
  int m_state;
  bit m_res  [NL];
  bit m_prev [NL];
  int m_total, m_combo, m_max, m_hit, m_miss;
  bit m_go;

  task automatic model_clear(input int nxt);
    for (int i = 0; i < NL; i++) begin m_res[i] = 0; m_prev[i] = 0; end
    m_total = 0; m_combo = 0; m_max = 0; m_hit = 0; m_miss = 0; m_go = 0;
    m_state = nxt;
  endtask

  task automatic model_step();
    int nh, nm, pre, mult;
    bit done_all;
    if (Reset) model_clear(0);
    else if (m_state == 0 || bus.keycode == KEY_IDLE)
      model_clear((m_state == 0 && bus.keycode == KEY_START) ? 1 : 0);
    else if (m_state == 1) begin
      nh = 0; nm = 0; pre = m_combo;
      for (int i = 0; i < NL; i++) if (!m_res[i]) begin
        if (bus.score_in[i] && !m_prev[i]) begin nh++; m_res[i] = 1; end
        else if (!bus.score_in[i] && int'(bus.drop_y[i]) >= 360) begin nm++; m_res[i] = 1; end
      end
      mult = (pre < 4) ? 1 : ((pre < 8) ? 2 : 4);
      m_total = m_total + nh * 10 * mult;
      if (m_total > 9999) m_total = 9999;
      m_combo = (nm > 0) ? 0 : ((pre + nh > 255) ? 255 : pre + nh);
      if (m_combo > m_max) m_max = m_combo;
      m_hit  = (m_hit + nh > 255) ? 255 : m_hit + nh;
      m_miss = (m_miss + nm > 255) ? 255 : m_miss + nm;
      done_all = 1;
      for (int i = 0; i < NL; i++) begin
        m_prev[i] = bus.score_in[i];
        done_all &= m_res[i];
      end
      if (done_all) begin m_state = 2; m_go = 1; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [46:0] exp_vec();
    return {14'(m_total), 8'(m_combo), 8'(m_max), 8'(m_hit), 8'(m_miss), m_go};
  endfunction

  function automatic logic [46:0] dut_vec();
    return {bus.total_score, bus.combo, bus.max_combo, bus.hit_count, bus.miss_count, bus.game_over};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic restart();
    bus.score_in = '0; bus.drop_y = '0;
    bus.keycode = KEY_IDLE;  tick();
    bus.keycode = KEY_START; tick();
    bus.keycode = 8'h00;
  endtask

  task automatic test_reset();
    Reset = 1'b1; bus.keycode = KEY_START; bbus.keycode = KEY_START;
    tick();
    Reset = 1'b0; bus.keycode = 8'h00; bbus.keycode = 8'h00;
    n_cmp++;
    if ({dut_vec(), bus.score_bcd} !== 63'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {dut_vec(), bus.score_bcd});
    end
    n_cmp++;
    if ({bbus.total_score, bbus.game_over, bbus.score_bcd} !== 31'd0) begin
      n_err++; $display("FAIL reset_big: got %h want 0", {bbus.total_score, bbus.game_over, bbus.score_bcd});
    end
  endtask

  task automatic test_first_hit();
    int k;
    bus.keycode = KEY_START; tick();
    bus.keycode = 8'h00; bus.score_in = 6'b000001; tick();
    n_cmp++;
    if ({bus.total_score, bus.combo, bus.hit_count} !== {14'd10, 8'd1, 8'd1}) begin
      n_err++; $display("FAIL first_hit: got %0d/%0d/%0d want 10/1/1", bus.total_score, bus.combo, bus.hit_count);
    end
    k = 0;
    while (bus.score_bcd !== 16'h0010 && k < 16) begin tick(); k++; end
    n_cmp++;
    if (bus.score_bcd !== 16'h0010) begin
      n_err++; $display("FAIL first_bcd: got %h want 0010", bus.score_bcd);
    end
  endtask

  task automatic test_combo();
    int exp_tot[5] = '{10, 20, 30, 40, 60};
    restart();
    for (int i = 0; i < 5; i++) begin
      bus.score_in[i] = 1'b1; tick();
      n_cmp++;
      if (bus.total_score !== 14'(exp_tot[i])) begin
        n_err++; $display("FAIL combo_total%0d: got %0d want %0d", i, bus.total_score, exp_tot[i]);
      end
    end
    n_cmp++;
    if ({bus.combo, bus.max_combo} !== {8'd5, 8'd5}) begin
      n_err++; $display("FAIL combo_count: got %0d/%0d want 5/5", bus.combo, bus.max_combo);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL combo_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_hit_miss();
    restart();
    bus.score_in[1] = 1'b1; bus.drop_y[2] = 10'd360; bus.drop_y[3] = 10'd359;
    tick();
    n_cmp++;
    if ({bus.total_score, bus.combo, bus.hit_count, bus.miss_count} !== {14'd10, 8'd0, 8'd1, 8'd1}) begin
      n_err++; $display("FAIL hit_miss: got %0d/%0d/%0d/%0d want 10/0/1/1",
                        bus.total_score, bus.combo, bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_done();
    int order[NL];
    int j, t, l;
    logic [46:0] snap;
    restart();
    for (int i = 0; i < NL; i++) order[i] = i;
    for (int i = NL - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i)); t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int k = 0; k < NL; k++) begin
      l = order[k];
      if ($urandom_range(0, 1) == 1) bus.score_in[l] = 1'b1;
      else bus.drop_y[l] = 10'($urandom_range(360, 1023));
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL done_step%0d: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    tick();
    n_cmp++;
    if (bus.game_over !== 1'b1) begin
      n_err++; $display("FAIL game_over: got %b want 1", bus.game_over);
    end
    snap = exp_vec();
    bus.score_in = '0; tick();
    bus.score_in = '1; bus.keycode = KEY_START; tick();
    bus.keycode = 8'h00; tick();
    n_cmp++;
    if (dut_vec() !== snap) begin
      n_err++; $display("FAIL done_frozen: got %h want %h", dut_vec(), snap);
    end
    bus.keycode = KEY_IDLE; tick();
    bus.keycode = 8'h00; bus.score_in = '0;
    n_cmp++;
    if (dut_vec() !== 47'd0) begin
      n_err++; $display("FAIL idle_clear: got %h want 0", dut_vec());
    end
    repeat (34) tick();
    n_cmp++;
    if (bus.score_bcd !== 16'h0000) begin
      n_err++; $display("FAIL idle_bcd: got %h want 0000", bus.score_bcd);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    bus.score_in = 6'b000111; tick();
    repeat (3) tick();
    Reset = 1'b1; bus.keycode = KEY_START; bus.score_in = '1;
    tick();
    Reset = 1'b0; bus.keycode = 8'h00;
    n_cmp++;
    if ({dut_vec(), bus.score_bcd} !== 63'd0) begin
      n_err++; $display("FAIL reset_mid: got %h want 0", {dut_vec(), bus.score_bcd});
    end
    bus.score_in = '0; tick();
    bus.score_in = 6'b000001; tick();
    n_cmp++;
    if (dut_vec() !== 47'd0 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int r;
    for (int round = 0; round < 6; round++) begin
      restart();
      for (int c = 0; c < 40; c++) begin
        for (int l = 0; l < NL; l++) begin
          if ($urandom_range(0, 3) == 0) bus.score_in[l] = 1'b1;
          else if ($urandom_range(0, 15) == 0) bus.score_in[l] = 1'b0;
          bus.drop_y[l] = 10'($urandom_range(0, 375));
        end
        r = int'($urandom_range(0, 59));
        bus.keycode = (r == 0) ? KEY_IDLE : ((r == 1) ? KEY_START : 8'h00);
        tick();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL random_r%0d_c%0d: got %h want %h", round, c, dut_vec(), exp_vec());
        end
      end
      bus.score_in = '0; bus.drop_y = '0; bus.keycode = 8'h00;
      repeat (34) tick();
      n_cmp++;
      if (bus.score_bcd !== to_bcd(m_total)) begin
        n_err++; $display("FAIL random_bcd%0d: got %h want %h", round, bus.score_bcd, to_bcd(m_total));
      end
    end
  endtask

  task automatic test_saturate();
    int l, batch, k;
    bbus.score_in = '0; bbus.drop_y = '0;
    bbus.keycode = KEY_START; tick();
    bbus.keycode = 8'h00;
    for (int i = 0; i < 8; i++) bbus.score_in[i] = 1'b1;
    tick();
    n_cmp++;
    if ({bbus.total_score, bbus.combo} !== {14'd80, 8'd8}) begin
      n_err++; $display("FAIL sat_first: got %0d/%0d want 80/8", bbus.total_score, bbus.combo);
    end
    l = 8; batch = 0;
    while (l < BIG) begin
      for (int i = 0; i < 12 && l < BIG; i++) begin bbus.score_in[l] = 1'b1; l++; end
      tick();
      batch++;
      if (batch == 1) begin
        n_cmp++;
        if (bbus.total_score !== 14'd560) begin
          n_err++; $display("FAIL sat_x4: got %0d want 560", bbus.total_score);
        end
      end
    end
    n_cmp++;
    if ({bbus.total_score, bbus.combo, bbus.max_combo, bbus.hit_count, bbus.miss_count, bbus.game_over}
        !== {14'd9999, 8'd255, 8'd255, 8'd255, 8'd0, 1'b1}) begin
      n_err++; $display("FAIL sat_final: got %0d/%0d/%0d/%0d/%0d/%b want 9999/255/255/255/0/1",
        bbus.total_score, bbus.combo, bbus.max_combo, bbus.hit_count, bbus.miss_count, bbus.game_over);
    end
    k = 0;
    while (bbus.score_bcd !== 16'h9999 && k < 40) begin tick(); k++; end
    n_cmp++;
    if (bbus.score_bcd !== 16'h9999) begin
      n_err++; $display("FAIL sat_bcd: got %h want 9999", bbus.score_bcd);
    end
  endtask

  initial begin
    bus.keycode = 8'h00; bus.score_in = '0; bus.drop_y = '0;
    bbus.keycode = 8'h00; bbus.score_in = '0; bbus.drop_y = '0;
    model_clear(0);
    #1;
    test_reset();
    test_first_hit();
    test_combo();
    test_hit_miss();
    test_done();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
